// File: rtl/hazard_fwd_unit.sv
// rtl/hazard_fwd_unit.sv - D-stage operand forwarding, data/MUDI stall detection and stall counter
module hazard_fwd_unit #(
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter int LUI_SH   = 16,
    parameter int PC_OFF   = 8,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int CW       = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [AW-1:0] rs_d,
    input  logic [AW-1:0] rt_d,
    input  logic          use_rs_d,
    input  logic          use_rt_d,
    input  logic          md_use_d,
    input  logic [AW-1:0] dst_e,
    input  logic [AW-1:0] dst_m,
    input  logic [AW-1:0] dst_w,
    input  logic [2:0]    wd_sel_e,
    input  logic [2:0]    wd_sel_m,
    input  logic [2:0]    wd_sel_w,
    input  logic [DW-1:0] ext_e,
    input  logic [DW-1:0] ext_m,
    input  logic [DW-1:0] ext_w,
    input  logic [DW-1:0] pc_e,
    input  logic [DW-1:0] pc_m,
    input  logic [DW-1:0] pc_w,
    input  logic [DW-1:0] alu_m,
    input  logic [DW-1:0] alu_w,
    input  logic [DW-1:0] mudi_m,
    input  logic [DW-1:0] mudi_w,
    input  logic [DW-1:0] dm_w,
    input  logic [DW-1:0] rf_rs,
    input  logic [DW-1:0] rf_rt,
    input  logic          start_mult_e,
    input  logic          start_div_e,
    output logic [DW-1:0] fwd_rs,
    output logic [DW-1:0] fwd_rt,
    output logic          stall,
    output logic          md_busy,
    output logic [CW-1:0] stall_cnt,
    output logic          md_drop
);
    localparam int MW = $clog2(DIV_LAT + 1);
    localparam logic [MW-1:0] MULT_LOAD = MW'(MULT_LAT);
    localparam logic [MW-1:0] DIV_LOAD  = MW'(DIV_LAT);

    logic [MW-1:0] md_cnt;
    logic [DW-1:0] val_e, val_m, val_w;
    logic          rdy_e, rdy_m, rdy_w;
    logic [DW:0]   res_rs, res_rt;
    logic          data_stall, md_stall;

    function automatic logic [DW-1:0] stage_val(input logic [2:0] sel, input logic [DW-1:0] alu,
                                                input logic [DW-1:0] ext, input logic [DW-1:0] dm,
                                                input logic [DW-1:0] pc, input logic [DW-1:0] mudi);
        case (sel)
            3'd0:    return alu;
            3'd1:    return ext << LUI_SH;
            3'd2:    return dm;
            3'd3:    return pc + DW'(PC_OFF);
            3'd4:    return mudi;
            default: return '0;
        endcase
    endfunction

    // Returns {pending, value}: pending means the nearest matching stage cannot supply data yet.
    function automatic logic [DW:0] resolve(
        input logic [AW-1:0] src, input logic [DW-1:0] rf,
        input logic [AW-1:0] de, input logic [AW-1:0] dm, input logic [AW-1:0] dw,
        input logic [2:0] se, input logic [2:0] sm, input logic [2:0] sw,
        input logic [DW-1:0] ve, input logic [DW-1:0] vm, input logic [DW-1:0] vw,
        input logic re, input logic rm, input logic rw);
        if (src == '0)
            return {1'b0, rf};
        if (de == src && se <= 3'd4)
            return re ? {1'b0, ve} : {1'b1, rf};
        if (dm == src && sm <= 3'd4)
            return rm ? {1'b0, vm} : {1'b1, rf};
        if (dw == src && sw <= 3'd4)
            return rw ? {1'b0, vw} : {1'b1, rf};
        return {1'b0, rf};
    endfunction

    always_comb begin
        val_e = stage_val(wd_sel_e, '0, ext_e, '0, pc_e, '0);
        val_m = stage_val(wd_sel_m, alu_m, ext_m, '0, pc_m, mudi_m);
        val_w = stage_val(wd_sel_w, alu_w, ext_w, dm_w, pc_w, mudi_w);
        rdy_e = (wd_sel_e == 3'd1) || (wd_sel_e == 3'd3);
        rdy_m = (wd_sel_m <= 3'd4) && (wd_sel_m != 3'd2);
        rdy_w = (wd_sel_w <= 3'd4);
        res_rs = resolve(rs_d, rf_rs, dst_e, dst_m, dst_w, wd_sel_e, wd_sel_m, wd_sel_w,
                         val_e, val_m, val_w, rdy_e, rdy_m, rdy_w);
        res_rt = resolve(rt_d, rf_rt, dst_e, dst_m, dst_w, wd_sel_e, wd_sel_m, wd_sel_w,
                         val_e, val_m, val_w, rdy_e, rdy_m, rdy_w);
        fwd_rs     = res_rs[DW-1:0];
        fwd_rt     = res_rt[DW-1:0];
        data_stall = (use_rs_d && res_rs[DW]) || (use_rt_d && res_rt[DW]);
        md_busy    = (md_cnt != '0);
        md_stall   = md_use_d && (md_busy || start_mult_e || start_div_e);
        stall      = data_stall || md_stall;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            md_cnt    <= '0;
            md_drop   <= 1'b0;
            stall_cnt <= '0;
        end else begin
            if (md_cnt == '0) begin
                if (start_div_e)
                    md_cnt <= DIV_LOAD;
                else if (start_mult_e)
                    md_cnt <= MULT_LOAD;
            end else begin
                md_cnt <= md_cnt - 1'b1;
                if (start_mult_e || start_div_e)
                    md_drop <= 1'b1;
            end
            if (stall && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
        end
    end
endmodule

// File: doc/hazard_fwd_unit.md
HAZARD_FWD_UNIT -- requirements
Module: hazard_fwd_unit

Interface
REQ-001 Parameters: DW=32, data width; AW=5, register-address width; LUI_SH=16, EXT shift for select 001; PC_OFF=8, link offset for select 011; MULT_LAT=5, multiply busy cycles; DIV_LAT=10, divide busy cycles; CW=16, stall-counter width.
REQ-002 Ports: clk in 1, clock; reset_n in 1, asynchronous active-low reset.
REQ-003 Ports: rs_d, rt_d in AW, D-stage source register numbers; use_rs_d, use_rt_d in 1, the source is read in D; md_use_d in 1, the D instruction reads or starts MUDI.
REQ-004 Ports: dst_e, dst_m, dst_w in AW, destination registers of the E, M and W stages; wd_sel_e, wd_sel_m, wd_sel_w in 3, write-data select per stage.
REQ-005 Ports: ext_e, ext_m, ext_w, pc_e, pc_m, pc_w, alu_m, alu_w, mudi_m, mudi_w, dm_w in DW, stage data sources.
REQ-006 Ports: rf_rs, rf_rt in DW, register-file read data.
REQ-007 Ports: start_mult_e, start_div_e in 1, MUDI start pulse issued from E.
REQ-008 Ports: fwd_rs, fwd_rt out DW, forwarded operands; stall out 1, holds PC and F/D and bubbles E; md_busy out 1; stall_cnt out CW; md_drop out 1, sticky flag set when a start is ignored.

Function
REQ-009 Stage value: select 000 gives ALU, 001 gives ext<<LUI_SH, 010 gives DM (W only), 011 gives pc+PC_OFF (DW-bit wrap), and 100 gives MUDI (M and W only); any other select gives 0.
REQ-010 E stage: only selects 001 and 011 are ready; M stage: all selects except 010 are ready; W stage: all selects are ready.
REQ-011 Forwarding, per operand, in strict priority E > M > W > rf: the first stage with dst==src, src!=0 and a valid select (000-100) forwards its value when ready.
REQ-012 Register 0 is never forwarded; the operand then equals the rf value.
REQ-013 Data stall when a used source matches the highest-priority stage whose value is not ready: E with select 000, 010 or 100; M with select 010.
REQ-014 A matching stage with an invalid select (101-111) does not forward, and lookup continues to the lower-priority stage.
REQ-015 MUDI counter: md_cnt, width clog2(DIV_LAT+1); start_mult_e loads MULT_LAT and start_div_e loads DIV_LAT, both only when md_cnt==0; otherwise md_cnt decrements to 0 and holds.
REQ-016 When both starts are asserted in the same cycle, the divide wins.
REQ-017 A start while md_cnt!=0 is ignored and sets md_drop until reset.
REQ-018 md_busy = (md_cnt!=0).
REQ-019 MUDI stall: md_use_d and (md_busy or start_mult_e or start_div_e).
REQ-020 stall = data stall OR MUDI stall, combinational, same cycle as its inputs.
REQ-021 stall_cnt increments on each clk edge where stall=1 and saturates at all-ones.
REQ-022 fwd_rs and fwd_rt are purely combinational; the only state is md_cnt, md_drop and stall_cnt.

Reset
REQ-023 When reset_n is low, md_cnt, md_drop and stall_cnt clear to 0 immediately, regardless of clk; md_busy=0.
REQ-024 Reset mid-operation aborts any MUDI operation; the first start after release loads normally.
REQ-025 While reset_n is low, stall depends only on combinational inputs.

Verification
REQ-026 rs_d=5, use_rs_d=1, dst_e=5, wd_sel_e=001, ext_e=0x1234, dst_m=5, wd_sel_m=000 -> fwd_rs=0x12340000 (E wins), stall=0.
REQ-027 rt_d=8, dst_e=8, wd_sel_e=000 -> stall=1; after the instruction advances to M (dst_m=8, wd_sel_m=000, alu_m=0xA5) -> fwd_rt=0xA5, stall=0.
REQ-028 rs_d=0, dst_e=0, wd_sel_e=011, rf_rs=0x77 -> fwd_rs=0x77, stall=0.
REQ-029 start_div_e pulse, then md_use_d=1 -> md_busy=1 for exactly 10 cycles, stall=1 for 11 cycles including the start cycle, stall_cnt=11.
REQ-030 start_mult_e with md_cnt=3 -> md_cnt keeps counting 2, 1, 0 and md_drop=1; reset_n low mid-count -> md_cnt=0, md_drop=0, stall_cnt=0 before the next clk edge.
REQ-031 CW=4 with stall held high for 20 cycles -> stall_cnt=15 and holds.
